// File: rtl/apb_slave_router_if.sv
// apb_slave_router_if: APB master-side bus plus the fanned-out slave-side bus of the router
interface apb_slave_router_if #(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
);
  logic                         PSEL;
  logic                         PENABLE;
  logic                         PWRITE;
  logic [ADDR_W-1:0]            PADDR;
  logic [DATA_W-1:0]            PWDATA;
  logic [DATA_W/8-1:0]          PSTRB;
  logic                         PREADY;
  logic                         PSLVERR;
  logic [DATA_W-1:0]            PRDATA;
  logic [NUM_SLAVES-1:0]        PSEL_S;
  logic                         PENABLE_S;
  logic                         PWRITE_S;
  logic [ADDR_W-1:0]            PADDR_S;
  logic [DATA_W-1:0]            PWDATA_S;
  logic [DATA_W/8-1:0]          PSTRB_S;
  logic [NUM_SLAVES-1:0]        PREADY_S;
  logic [NUM_SLAVES-1:0]        PSLVERR_S;
  logic [NUM_SLAVES*DATA_W-1:0] PRDATA_S;
  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PREADY, PSLVERR, PRDATA,
    output PSEL_S, PENABLE_S, PWRITE_S, PADDR_S, PWDATA_S, PSTRB_S,
    input  PREADY_S, PSLVERR_S, PRDATA_S
  );
  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PREADY, PSLVERR, PRDATA,
    input  PSEL_S, PENABLE_S, PWRITE_S, PADDR_S, PWDATA_S, PSTRB_S,
    output PREADY_S, PSLVERR_S, PRDATA_S
  );
endinterface

// File: rtl/apb_slave_router.sv
// apb_slave_router: registered APB bridge routing one master to NUM_SLAVES slaves by address field.
// Define APB_TIMEOUT_EN to abort slave accesses that stay unready for TIMEOUT_CYCLES cycles.
module apb_slave_router #(
  parameter int NUM_SLAVES     = 4,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int SEL_LSB        = 12,
  parameter int SEL_W          = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  apb_slave_router_if.slave bus,
  output logic              busy
);
  localparam int IW = NUM_SLAVES > 1 ? $clog2(NUM_SLAVES) : 1;
  if (NUM_SLAVES < 1 || NUM_SLAVES > 16 || DATA_W % 8 != 0 || TIMEOUT_CYCLES < 1 || SEL_W < IW) begin : g_bad_params
    $error("apb_slave_router: illegal parameter set");
  end
  typedef enum logic [1:0] {IDLE, S_SETUP, S_ACCESS, RESP} state_t;
  state_t              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [DATA_W/8-1:0] pstrb_q, pstrb_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [SEL_W-1:0]    sel_raw;
  logic                mapped;
  logic                expired;
  assign sel_raw = bus.PADDR[SEL_LSB +: SEL_W];
  assign mapped  = 32'(sel_raw) < NUM_SLAVES;
`ifdef APB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1) > 8 ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CW-1:0] cnt_q, cnt_d;
  // cnt_q counts unready ACCESS cycles already spent; abort at the last permitted one
  assign expired = cnt_q == CW'(TIMEOUT_CYCLES - 1);
  assign cnt_d   = state_q == S_ACCESS ? cnt_q + 1'b1 : '0;
  always_ff @(posedge clk)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
`else
  assign expired = 1'b0;
`endif
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    pwrite_d = pwrite_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pstrb_d  = pstrb_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: if (bus.PSEL && !bus.PENABLE) begin
        idx_d    = sel_raw[IW-1:0];
        pwrite_d = bus.PWRITE;
        paddr_d  = bus.PADDR;
        pwdata_d = bus.PWDATA;
        pstrb_d  = bus.PSTRB;
        err_d    = !mapped;
        rdata_d  = '0;
        state_d  = mapped ? S_SETUP : RESP;
      end
      S_SETUP: state_d = S_ACCESS;
      S_ACCESS: if (bus.PREADY_S[idx_q]) begin
        err_d   = bus.PSLVERR_S[idx_q];
        rdata_d = pwrite_q ? '0 : bus.PRDATA_S[int'(idx_q)*DATA_W +: DATA_W];
        state_d = RESP;
      end else if (expired) begin
        err_d   = 1'b1;
        rdata_d = '0;
        state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      pwrite_q <= pwrite_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pstrb_q  <= pstrb_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  assign bus.PSEL_S    = state_q == S_SETUP || state_q == S_ACCESS ? NUM_SLAVES'(1) << idx_q : '0;
  assign bus.PENABLE_S = state_q == S_ACCESS;
  assign bus.PWRITE_S  = pwrite_q;
  assign bus.PADDR_S   = paddr_q;
  assign bus.PWDATA_S  = pwdata_q;
  assign bus.PSTRB_S   = pstrb_q;
  assign bus.PREADY    = state_q == RESP;
  assign bus.PSLVERR   = state_q == RESP && err_q;
  assign bus.PRDATA    = state_q == RESP ? rdata_q : '0;
  assign busy          = state_q != IDLE;
endmodule

// File: tb/tb_apb_slave_router.sv
// tb_apb_slave_router: directed and random APB transfers checked against a latency/response model.
module tb_apb_slave_router;
  localparam int NS = 4;
  localparam int TO = 8;
`ifdef APB_TIMEOUT_EN
  localparam bit TO_ON = 1'b1;
`else
  localparam bit TO_ON = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_fail = 0;
  apb_slave_router_if #(.NUM_SLAVES(NS), .ADDR_W(32), .DATA_W(32)) bus ();
  apb_slave_router #(.NUM_SLAVES(NS), .ADDR_W(32), .DATA_W(32), .SEL_LSB(12), .SEL_W(4),
                     .TIMEOUT_CYCLES(TO)) dut (.clk(clk), .rst(rst), .bus(bus), .busy(busy));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic idle_master();
    bus.PSEL = 1'b0;
    bus.PENABLE = 1'b0;
    bus.PREADY_S = '0;
    bus.PSLVERR_S = '0;
  endtask
  task automatic check_all_zero(input string tag);
    check(tag, {bus.PREADY, bus.PSLVERR, bus.PRDATA, bus.PSEL_S, bus.PENABLE_S, bus.PWRITE_S,
                bus.PADDR_S, bus.PWDATA_S, bus.PSTRB_S, busy}, '0);
  endtask
  // One master transfer; slave idx waits 'waits' ACCESS cycles before PREADY_S (never if >= TO with timeout)
  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb,
                      input int waits, input bit serr, input logic [31:0] rd, input bit drop);
    int idx, exp_lat, acc_n;
    bit mapped, exp_err, done;
    logic [31:0] exp_rd;
    idx = int'(addr[15:12]);
    mapped = idx < NS;
    acc_n = 0;
    done = 1'b0;
    if (!mapped) begin
      exp_lat = 1; exp_err = 1'b1; exp_rd = '0;
    end else if (TO_ON && waits >= TO) begin
      exp_lat = 2 + TO; exp_err = 1'b1; exp_rd = '0;
    end else begin
      exp_lat = 3 + waits; exp_err = serr; exp_rd = wr ? 32'h0 : rd;
    end
    @(posedge clk); #1;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = wr;
    bus.PADDR = addr; bus.PWDATA = wdata; bus.PSTRB = strb;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      bus.PSEL = !drop;
      bus.PENABLE = !drop;
      bus.PREADY_S = 4'($urandom);
      bus.PSLVERR_S = 4'($urandom);
      for (int k = 0; k < NS; k++) bus.PRDATA_S[k*32 +: 32] = $urandom;
      if (mapped) begin
        if (bus.PSEL_S[idx] && bus.PENABLE_S) begin
          acc_n++;
          bus.PREADY_S[idx] = acc_n > waits;
          bus.PSLVERR_S[idx] = serr;
          if (acc_n > waits) bus.PRDATA_S[idx*32 +: 32] = rd;
        end
      end
      @(negedge clk);
      check("psel_s_onehot", 128'($countones(bus.PSEL_S) <= 1), 128'(1));
      if (c == 1) begin
        check("setup_psel_s", {bus.PSEL_S, bus.PENABLE_S}, {(mapped ? 4'(1 << idx) : 4'b0), 1'b0});
        check("shared_regs", {bus.PWRITE_S, bus.PSTRB_S, bus.PADDR_S, bus.PWDATA_S}, {wr, strb, addr, wdata});
      end
      if (c == 2 && mapped) check("access_psel_s", {bus.PSEL_S, bus.PENABLE_S}, {4'(1 << idx), 1'b1});
      if (bus.PREADY) begin
        check("latency", 128'(c), 128'(exp_lat));
        check("resp_err_data", {bus.PSLVERR, bus.PRDATA}, {exp_err, exp_rd});
        check("resp_slave_idle", {bus.PSEL_S, bus.PENABLE_S}, '0);
        done = 1'b1;
        break;
      end
    end
    if (!done) check("pready_timeout", 128'(0), 128'(1));
    @(posedge clk); #1;
    idle_master();
    @(negedge clk);
    check("after_resp", {busy, bus.PREADY, bus.PSLVERR, bus.PRDATA}, '0);
  endtask
  initial begin
    bit wr, serr;
    int idx, waits;
    logic [31:0] addr;
    idle_master();
    bus.PWRITE = 1'b0; bus.PADDR = '0; bus.PWDATA = '0; bus.PSTRB = '0; bus.PRDATA_S = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset_state");
    @(posedge clk); #1;
    rst = 1'b0;
    // orphan ACCESS phase in IDLE must not start a transfer
    bus.PSEL = 1'b1; bus.PENABLE = 1'b1; bus.PADDR = 32'h1000;
    @(negedge clk);
    check("orphan_ignored", {busy, bus.PSEL_S}, '0);
    @(posedge clk); #1;
    idle_master();
    xfer(1'b1, 32'h0000_1004, 32'hA5A5_5A5A, 4'hF, 0, 1'b0, 32'h1111_2222, 1'b0);
    xfer(1'b0, 32'h0000_3000, 32'h0, 4'h0, 2, 1'b0, 32'hDEAD_BEEF, 1'b0);
    xfer(1'b0, 32'h0000_5000, 32'h0, 4'h0, 0, 1'b0, 32'h1234_5678, 1'b0);
    xfer(1'b1, 32'h0000_2010, 32'h0BAD_F00D, 4'h3, 1, 1'b1, 32'h0, 1'b0);
    xfer(1'b0, 32'h0000_0010, 32'h0, 4'h0, 1, 1'b0, 32'hCAFE_0001, 1'b1);
`ifdef APB_TIMEOUT_EN
    xfer(1'b0, 32'h0000_0020, 32'h0, 4'h0, 1000, 1'b0, 32'h5555_AAAA, 1'b0);
`endif
    // reset during S_ACCESS: no PREADY, everything back to zero
    @(posedge clk); #1;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1; bus.PADDR = 32'h0000_2000;
    bus.PWDATA = 32'h7777_8888; bus.PSTRB = 4'hF;
    @(posedge clk); #1;
    bus.PENABLE = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("pre_reset_access", {busy, bus.PSEL_S, bus.PENABLE_S}, {1'b1, 4'b0100, 1'b1});
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle_master();
    @(negedge clk);
    check_all_zero("mid_reset");
    xfer(1'b1, 32'h0000_2008, 32'h1357_9BDF, 4'hC, 0, 1'b0, 32'h0, 1'b0);
    for (int t = 0; t < 24; t++) begin
      wr = 1'($urandom);
      serr = 1'($urandom);
      idx = $urandom_range(0, 5);
      waits = $urandom_range(0, 4);
      addr = $urandom;
      addr[15:12] = 4'(idx);
      xfer(wr, addr, $urandom, 4'($urandom), waits, serr, $urandom, 1'($urandom_range(0, 3) == 0));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
